ir_queue: RTL and testbench

IR_QUEUE -- requirements
Module: ir_queue

---
 rtl/ir_queue.sv | 85 ++++++++
 tb/tb_ir_queue.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ir_queue.sv
// Instruction register fed by a circular prefetch queue sharing one tri-state bus.
// The current IR's address field is returned on the bus while ir_valid is high.
module ir_queue #(
  parameter int unsigned OP_W   = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        ir_load,
  input  logic                        ir_next,
  input  logic                        ir_valid,
  inout  wire  [OP_W+ADDR_W-1:0]      data,
  output logic [OP_W-1:0]             opcode,
  output logic                        cur_valid,
  output logic [$clog2(DEPTH):0]      q_count,
  output logic                        q_full,
  output logic                        q_empty,
  output logic                        ovf_err
);

  localparam int unsigned DATA_W = OP_W + ADDR_W;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] ir_q;

  logic load_eff;
  logic push;
  logic pop;
  logic drop;

  // The bus is ours while ir_valid is high, so a load in that cycle would capture our own drive.
  assign load_eff = ir_load & ~ir_valid;
  assign pop      = ir_next & ~q_empty;
  assign push     = load_eff & (~q_full | pop);
  assign drop     = load_eff & q_full & ~pop;

  assign q_full  = (q_count == CNT_W'(DEPTH));
  assign q_empty = (q_count == CNT_W'(0));

  assign opcode = ir_q[DATA_W-1:ADDR_W];
  assign data   = ir_valid ? {{OP_W{1'b0}}, ir_q[ADDR_W-1:0]} : {DATA_W{1'bz}};

  // Storage is not reset; it is only read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      q_count   <= '0;
      ir_q      <= '0;
      cur_valid <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        ir_q   <= mem[rd_ptr];
      end
      if (ir_next) begin
        cur_valid <= pop;
      end
      case ({push, pop})
        2'b10:   q_count <= q_count + CNT_W'(1);
        2'b01:   q_count <= q_count - CNT_W'(1);
        default: q_count <= q_count;
      endcase
      if (drop) begin
        ovf_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ir_queue.sv
// Directed bench for ir_queue with default parameters (8-bit opcode/address, depth 4).
module tb_ir_queue;

  logic        clk;
  logic        nrst;
  logic        ir_load;
  logic        ir_next;
  logic        ir_valid;
  logic        drv_en;
  logic [15:0] drv_data;
  wire  [15:0] data;
  logic [7:0]  opcode;
  logic        cur_valid;
  logic [2:0]  q_count;
  logic        q_full;
  logic        q_empty;
  logic        ovf_err;

  int n_checks = 0;
  int n_fail   = 0;

  assign data = drv_en ? drv_data : 16'bz;

  ir_queue dut (
    .clk       (clk),
    .nrst      (nrst),
    .ir_load   (ir_load),
    .ir_next   (ir_next),
    .ir_valid  (ir_valid),
    .data      (data),
    .opcode    (opcode),
    .cur_valid (cur_valid),
    .q_count   (q_count),
    .q_full    (q_full),
    .q_empty   (q_empty),
    .ovf_err   (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic ld, input logic nx, input logic [15:0] v);
    drv_data = v;
    drv_en   = ld;
    ir_load  = ld;
    ir_next  = nx;
    tick();
    ir_load  = 1'b0;
    ir_next  = 1'b0;
    drv_en   = 1'b0;
  endtask

  // Reset pulse placed between clock edges.
  task automatic pulse_reset();
    nrst = 1'b0;
    #1;
    nrst = 1'b1;
  endtask

  initial begin
    logic [15:0] vals [6];
    nrst = 1'b0; ir_load = 1'b0; ir_next = 1'b0; ir_valid = 1'b0;
    drv_en = 1'b0; drv_data = '0;
    #3;
    check("rst_count", 32'(q_count), 32'd0);
    check("rst_empty", 32'(q_empty), 32'd1);
    check("rst_full", 32'(q_full), 32'd0);
    check("rst_opcode", 32'(opcode), 32'h0);
    check("rst_cur_valid", 32'(cur_valid), 32'd0);
    check("rst_ovf", 32'(ovf_err), 32'd0);
    #4;
    nrst = 1'b1;
    tick();

    // single load then next
    cycle(1'b1, 1'b0, 16'h0F0F);
    check("single_count", 32'(q_count), 32'd1);
    check("single_not_empty", 32'(q_empty), 32'd0);
    cycle(1'b0, 1'b1, 16'h0);
    check("single_opcode", 32'(opcode), 32'h0F);
    check("single_cur_valid", 32'(cur_valid), 32'd1);
    check("single_empty", 32'(q_empty), 32'd1);
    ir_valid = 1'b1;
    #1;
    check("single_bus", 32'(data), 32'h000F);
    ir_valid = 1'b0;
    tick();

    // fill and overflow
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b1, 1'b0, {8'(i), 8'(i)});
      if (i == 4) begin
        check("fill_full", 32'(q_full), 32'd1);
        check("fill_no_ovf", 32'(ovf_err), 32'd0);
      end
    end
    check("ovf_set", 32'(ovf_err), 32'd1);
    check("ovf_count", 32'(q_count), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b0, 1'b1, 16'h0);
      check("drain_opcode", 32'(opcode), 32'(i));
    end
    check("drain_empty", 32'(q_empty), 32'd1);
    cycle(1'b0, 1'b1, 16'h0);
    check("pop_empty_cur_valid", 32'(cur_valid), 32'd0);
    check("pop_empty_hold", 32'(opcode), 32'h04);
    check("ovf_sticky", 32'(ovf_err), 32'd1);

    // wrap-around
    pulse_reset();
    vals[0] = 16'h1181; vals[1] = 16'h2282; vals[2] = 16'h3383;
    vals[3] = 16'h4484; vals[4] = 16'h5585; vals[5] = 16'h6686;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, vals[r*3+i]);
      check("wrap_count3", 32'(q_count), 32'd3);
      for (int i = 0; i < 3; i++) begin
        cycle(1'b0, 1'b1, 16'h0);
        check("wrap_opcode", 32'(opcode), 32'(vals[r*3+i][15:8]));
      end
    end
    check("wrap_count0", 32'(q_count), 32'd0);

    // simultaneous load+next on full, then on empty
    pulse_reset();
    for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b0, {4'hA, 4'(i), 8'hC0 + 8'(i)});
    cycle(1'b1, 1'b1, 16'hA5C5);
    check("full_ln_count", 32'(q_count), 32'd4);
    check("full_ln_ovf", 32'(ovf_err), 32'd0);
    check("full_ln_opcode", 32'(opcode), 32'hA1);
    for (int i = 2; i <= 5; i++) begin
      cycle(1'b0, 1'b1, 16'h0);
      check("full_ln_drain", 32'(opcode), 32'({4'hA, 4'(i)}));
    end
    cycle(1'b1, 1'b1, 16'hB1D1);
    check("empty_ln_count", 32'(q_count), 32'd1);
    check("empty_ln_cur_valid", 32'(cur_valid), 32'd0);
    check("empty_ln_hold", 32'(opcode), 32'hA5);

    // bus conflict: load ignored while IR drives the bus
    ir_valid = 1'b1;
    ir_load  = 1'b1;
    #1;
    check("conflict_bus", 32'(data), 32'h00C5);
    tick();
    ir_load  = 1'b0;
    check("conflict_count", 32'(q_count), 32'd1);
    ir_valid = 1'b0;

    // reset mid-operation
    pulse_reset();
    for (int i = 1; i <= 5; i++) cycle(1'b1, 1'b0, {8'h10 + 8'(i), 8'h20 + 8'(i)});
    cycle(1'b0, 1'b1, 16'h0);
    check("pre_rst_count", 32'(q_count), 32'd3);
    check("pre_rst_ovf", 32'(ovf_err), 32'd1);
    nrst = 1'b0;
    #1;
    check("mid_rst_count", 32'(q_count), 32'd0);
    check("mid_rst_cur_valid", 32'(cur_valid), 32'd0);
    check("mid_rst_ovf", 32'(ovf_err), 32'd0);
    check("mid_rst_opcode", 32'(opcode), 32'h0);
    check("mid_rst_empty", 32'(q_empty), 32'd1);
    nrst = 1'b1;
    cycle(1'b1, 1'b0, 16'h7E3C);
    cycle(1'b0, 1'b1, 16'h0);
    check("resume_opcode", 32'(opcode), 32'h7E);
    check("resume_cur_valid", 32'(cur_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
